// File: rtl/s2mm_pkg.sv
// Shared types and constants for the S2MM capture controller.
// Holds the controller state encoding and the all-ones stream keep value.
package s2mm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } state_e;

    localparam int KEEP_MAX_W = 64;
    localparam logic [KEEP_MAX_W-1:0] TKEEP_ONES = '1;

endpackage

// File: rtl/s2mm_out_reg.sv
// Single-entry AXI-Stream output register with the tvalid/tready handshake.
// Decides per requested sample whether it loads into the register or is dropped.
module s2mm_out_reg
    import s2mm_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_req_i,
    input  logic [DATA_W-1:0] din_i,
    input  logic              last_i,
    input  logic              tready_i,
    output logic [DATA_W-1:0] tdata_o,
    output logic [DATA_W/8-1:0] tkeep_o,
    output logic              tvalid_o,
    output logic              tlast_o,
    output logic              load_o,
    output logic              drop_o,
    output logic              accept_o
);

    logic [DATA_W-1:0] tdata_q;
    logic              tvalid_q;
    logic              tlast_q;

    assign accept_o = tvalid_q & tready_i;
    assign load_o   = sample_req_i & (~tvalid_q | tready_i);
    assign drop_o   = sample_req_i & tvalid_q & ~tready_i;

    // NOTE: non-blocking assignments keep every register updating from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
        end else if (load_o) begin
            tdata_q  <= din_i;
            tlast_q  <= last_i;
            tvalid_q <= 1'b1;
        end else if (accept_o) begin
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
        end
    end

    assign tdata_o  = tdata_q;
    assign tvalid_o = tvalid_q;
    assign tlast_o  = tlast_q;
    assign tkeep_o  = TKEEP_ONES[DATA_W/8-1:0];

endmodule

// File: rtl/s2mm_frame_ctrl.sv
// Frame capture controller feeding an S2MM stream sink (IDLE/ARM/RUN/FLUSH/DONE).
// Define S2MM_DROP_CNT_EN to build the saturating dropped-sample counter.
module s2mm_frame_ctrl
    import s2mm_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_start,
    input  logic                cfg_abort,
    input  logic [LEN_W-1:0]    cfg_frame_len,
    input  logic [LEN_W-1:0]    cfg_frame_num,
    input  logic                trig,
    input  logic [DATA_W-1:0]   din,
    input  logic                din_valid,
    output logic [DATA_W-1:0]   m_axis_tdata,
    output logic [DATA_W/8-1:0] m_axis_tkeep,
    output logic                m_axis_tvalid,
    output logic                m_axis_tlast,
    input  logic                m_axis_tready,
    output logic                busy,
    output logic                done,
    output logic                aborted,
    output logic [LEN_W-1:0]    frames_done,
    output logic [LEN_W-1:0]    drop_cnt
);

    state_e           state_q;
    logic [LEN_W-1:0] frame_len_q;
    logic [LEN_W-1:0] frame_num_q;
    logic [LEN_W-1:0] beat_idx_q;
    logic [LEN_W-1:0] beat_idx_d;
    logic [LEN_W-1:0] frames_done_q;
    logic             busy_q;
    logic             done_q;
    logic             aborted_q;

    logic start_acc;
    logic last_beat;
    logic final_accept;
    logic sample_req;
    logic load;
    logic drop;
    logic accept;

    assign start_acc    = (state_q == ST_IDLE) && cfg_start;
    assign last_beat    = (beat_idx_q == frame_len_q - LEN_W'(1));
    assign beat_idx_d   = last_beat ? '0 : beat_idx_q + LEN_W'(1);
    // Completion outranks a same-cycle abort and suppresses any further sample.
    assign final_accept = (state_q == ST_RUN) && accept && m_axis_tlast &&
                          (frame_num_q != '0) &&
                          (frames_done_q + LEN_W'(1) == frame_num_q);
    assign sample_req   = (state_q == ST_RUN) && din_valid && !cfg_abort && !final_accept;

    s2mm_out_reg #(
        .DATA_W (DATA_W)
    ) u_out_reg (
        .clk          (clk),
        .rst          (rst),
        .sample_req_i (sample_req),
        .din_i        (din),
        .last_i       (last_beat),
        .tready_i     (m_axis_tready),
        .tdata_o      (m_axis_tdata),
        .tkeep_o      (m_axis_tkeep),
        .tvalid_o     (m_axis_tvalid),
        .tlast_o      (m_axis_tlast),
        .load_o       (load),
        .drop_o       (drop),
        .accept_o     (accept)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            frame_len_q <= LEN_W'(1);
            frame_num_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (cfg_start) begin
                        frame_len_q <= (cfg_frame_len == '0) ? LEN_W'(1) : cfg_frame_len;
                        frame_num_q <= cfg_frame_num;
                        aborted_q   <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (cfg_abort) begin
                        aborted_q <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= ST_IDLE;
                    end else if (trig) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (final_accept) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_DONE;
                    end else if (cfg_abort) begin
                        aborted_q <= 1'b1;
                        state_q   <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (!m_axis_tvalid || accept) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            beat_idx_q    <= '0;
            frames_done_q <= '0;
        end else begin
            if (load) begin
                beat_idx_q <= beat_idx_d;
            end
            if (accept && m_axis_tlast) begin
                frames_done_q <= frames_done_q + LEN_W'(1);
            end
        end
    end

`ifdef S2MM_DROP_CNT_EN
    logic [LEN_W-1:0] drop_cnt_q;

    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            drop_cnt_q <= '0;
        end else if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_q <= drop_cnt_q + LEN_W'(1);
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    logic unused_drop;
    assign unused_drop = drop;
    assign drop_cnt    = '0;
`endif

    assign busy        = busy_q;
    assign done        = done_q;
    assign aborted     = aborted_q;
    assign frames_done = frames_done_q;

endmodule

// File: tb/tb_s2mm_frame_ctrl.sv
// Scoreboard bench for s2mm_frame_ctrl: stimulus queues expected beats, a
// negedge monitor pops and compares every accepted beat.
module tb_s2mm_frame_ctrl;

    localparam int DATA_W = 32;
    localparam int LEN_W  = 16;
`ifdef S2MM_DROP_CNT_EN
    localparam int EXP_DROPS = 5;
`else
    localparam int EXP_DROPS = 0;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic                cfg_start;
    logic                cfg_abort;
    logic [LEN_W-1:0]    cfg_frame_len;
    logic [LEN_W-1:0]    cfg_frame_num;
    logic                trig;
    logic [DATA_W-1:0]   din;
    logic                din_valid;
    logic [DATA_W-1:0]   m_axis_tdata;
    logic [DATA_W/8-1:0] m_axis_tkeep;
    logic                m_axis_tvalid;
    logic                m_axis_tlast;
    logic                m_axis_tready;
    logic                busy;
    logic                done;
    logic                aborted;
    logic [LEN_W-1:0]    frames_done;
    logic [LEN_W-1:0]    drop_cnt;

    always #5 clk = ~clk;

    s2mm_frame_ctrl #(
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_start     (cfg_start),
        .cfg_abort     (cfg_abort),
        .cfg_frame_len (cfg_frame_len),
        .cfg_frame_num (cfg_frame_num),
        .trig          (trig),
        .din           (din),
        .din_valid     (din_valid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .busy          (busy),
        .done          (done),
        .aborted       (aborted),
        .frames_done   (frames_done),
        .drop_cnt      (drop_cnt)
    );

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    beat_t exp_q[$];
    int    n_tests      = 0;
    int    n_fail       = 0;
    int    cyc          = 0;
    int    last_acc_cyc = -1;
    int    acc_cnt      = 0;
    int    done_cnt     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic [DATA_W-1:0] data, input logic last);
        beat_t b;
        b.data = data;
        b.last = last;
        exp_q.push_back(b);
    endtask

    // One clock: inputs change 1 time unit after the edge; din ramps by one per cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        din       = din + 1;
        cfg_start = 1'b0;
        cfg_abort = 1'b0;
    endtask

    task automatic start_capture(input int len, input int num, input logic [DATA_W-1:0] base);
        cfg_frame_len = LEN_W'(len);
        cfg_frame_num = LEN_W'(num);
        cfg_start     = 1'b1;
        din           = base;
        acc_cnt       = 0;
    endtask

    task automatic wait_done(input string name, input int max_cyc);
        bit seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            tick();
            if (done === 1'b1) seen = 1'b1;
        end
        check({name, "_done_seen"}, 64'(seen), 64'd1);
    endtask

    // Monitor: compare every accepted beat against the scoreboard queue.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (m_axis_tvalid === 1'b1) begin
                check("tkeep_ones", 64'(m_axis_tkeep), 64'hF);
            end
            if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
                acc_cnt++;
                last_acc_cyc = cyc;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_unexpected_beat: got data %0h last %0b, expected no beat",
                             m_axis_tdata, m_axis_tlast);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("sb_tdata", 64'(m_axis_tdata), 64'(e.data));
                    check("sb_tlast", 64'(m_axis_tlast), 64'(e.last));
                end
            end
            if (done === 1'b1) done_cnt++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        rst           = 1'b1;
        cfg_start     = 1'b0;
        cfg_abort     = 1'b0;
        cfg_frame_len = '0;
        cfg_frame_num = '0;
        trig          = 1'b1;
        din           = '0;
        din_valid     = 1'b1;
        m_axis_tready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_tlast", 64'(m_axis_tlast), 64'd0);
        check("rst_tdata", 64'(m_axis_tdata), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_aborted", 64'(aborted), 64'd0);
        check("rst_frames_done", 64'(frames_done), 64'd0);
        check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        rst = 1'b0;
        tick();

        // Two frames of four beats; samples from cycles 2..9 of the capture.
        start_capture(4, 2, 32'h1100_0000);
        for (int i = 0; i < 8; i++) push_exp(32'h1100_0002 + 32'(i), (i % 4) == 3);
        tick();
        check("t1_busy_arm", 64'(busy), 64'd1);
        wait_done("t1", 40);
        check("t1_done_latency", 64'(cyc), 64'(last_acc_cyc + 1));
        check("t1_frames_done", 64'(frames_done), 64'd2);
        check("t1_beats", 64'(acc_cnt), 64'd8);
        tick();
        check("t1_done_pulse", 64'(done), 64'd0);
        check("t1_busy_idle", 64'(busy), 64'd0);
        check("t1_queue_empty", 64'(exp_q.size()), 64'd0);

        // frame_len 0 behaves as 1: every beat is a frame end.
        start_capture(0, 3, 32'h2200_0000);
        for (int i = 0; i < 3; i++) push_exp(32'h2200_0002 + 32'(i), 1'b1);
        wait_done("t2", 40);
        check("t2_frames_done", 64'(frames_done), 64'd3);
        check("t2_queue_empty", 64'(exp_q.size()), 64'd0);
        tick();

        // Five stalled cycles with a full register: samples drop, tdata holds.
        start_capture(4, 1, 32'h3300_0000);
        push_exp(32'h3300_0002, 1'b0);
        push_exp(32'h3300_0003, 1'b0);
        push_exp(32'h3300_0009, 1'b0);
        push_exp(32'h3300_000A, 1'b1);
        repeat (4) tick();
        m_axis_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_tvalid", 64'(m_axis_tvalid), 64'd1);
            check("t3_hold_tdata", 64'(m_axis_tdata), 64'h3300_0003);
            tick();
        end
        m_axis_tready = 1'b1;
        check("t3_drop_cnt", 64'(drop_cnt), 64'(EXP_DROPS));
        wait_done("t3", 40);
        check("t3_frames_done", 64'(frames_done), 64'd1);
        check("t3_queue_empty", 64'(exp_q.size()), 64'd0);
        tick();

        // Continuous mode, abort while a beat is stalled: flush it, no done.
        dc = done_cnt;
        start_capture(2, 0, 32'h4400_0000);
        for (int i = 0; i < 7; i++) push_exp(32'h4400_0002 + 32'(i), (i % 2) == 1);
        repeat (9) tick();
        check("t4_frames_before_abort", 64'(frames_done), 64'd3);
        m_axis_tready = 1'b0;
        cfg_abort     = 1'b1;
        tick();
        check("t4_flush_busy", 64'(busy), 64'd1);
        check("t4_flush_aborted", 64'(aborted), 64'd1);
        check("t4_flush_tdata", 64'(m_axis_tdata), 64'h4400_0008);
        tick();
        check("t4_flush_tvalid", 64'(m_axis_tvalid), 64'd1);
        check("t4_flush_tdata2", 64'(m_axis_tdata), 64'h4400_0008);
        m_axis_tready = 1'b1;
        tick();
        check("t4_idle_busy", 64'(busy), 64'd0);
        check("t4_idle_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("t4_aborted", 64'(aborted), 64'd1);
        check("t4_frames_done", 64'(frames_done), 64'd3);
        tick();
        check("t4_no_done", 64'(done_cnt), 64'(dc));
        check("t4_queue_empty", 64'(exp_q.size()), 64'd0);

        // cfg_start during RUN is ignored; the first capture completes unchanged.
        start_capture(2, 2, 32'h5500_0000);
        for (int i = 0; i < 4; i++) push_exp(32'h5500_0002 + 32'(i), (i % 2) == 1);
        check("t5_aborted_cleared_pre", 64'(aborted), 64'd1);
        repeat (5) tick();
        cfg_frame_len = LEN_W'(3);
        cfg_frame_num = LEN_W'(1);
        cfg_start     = 1'b1;
        tick();
        check("t5_aborted_cleared", 64'(aborted), 64'd0);
        check("t5_frames_kept", 64'(frames_done), 64'd1);
        check("t5_busy_kept", 64'(busy), 64'd1);
        wait_done("t5", 20);
        check("t5_done_latency", 64'(cyc), 64'(last_acc_cyc + 1));
        check("t5_frames_done", 64'(frames_done), 64'd2);
        check("t5_queue_empty", 64'(exp_q.size()), 64'd0);
        tick();

        // Reset while beat 2 of a frame is pending, then a fresh capture.
        start_capture(4, 1, 32'h6600_0000);
        push_exp(32'h6600_0002, 1'b0);
        push_exp(32'h6600_0003, 1'b0);
        repeat (5) tick();
        check("t6_pending_tdata", 64'(m_axis_tdata), 64'h6600_0004);
        m_axis_tready = 1'b0;
        rst           = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("t6_rst_busy", 64'(busy), 64'd0);
        check("t6_rst_tdata", 64'(m_axis_tdata), 64'd0);
        check("t6_rst_frames", 64'(frames_done), 64'd0);
        m_axis_tready = 1'b1;
        start_capture(4, 1, 32'h7700_0000);
        for (int i = 0; i < 4; i++) push_exp(32'h7700_0002 + 32'(i), i == 3);
        wait_done("t6", 30);
        check("t6_frames_done", 64'(frames_done), 64'd1);
        check("t6_beats", 64'(acc_cnt), 64'd4);
        tick();
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/s2mm_frame_ctrl.md
S2MM_FRAME_CTRL -- requirements
Module: s2mm_frame_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of the sample and stream data.
REQ-002 SHALL have parameter LEN_W, default 16, width of the length, count and status counters.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk, in, 1, sole clock.
REQ-005 SHALL have port rst, in, 1, synchronous active-high reset.
REQ-006 SHALL have port cfg_start, in, 1, one-cycle pulse that arms a capture.
REQ-007 SHALL have port cfg_abort, in, 1, one-cycle pulse that stops capture.
REQ-008 SHALL have port cfg_frame_len, in, LEN_W, beats per frame; 0 is treated as 1.
REQ-009 SHALL have port cfg_frame_num, in, LEN_W, frames per capture; 0 means continuous.
REQ-010 SHALL have port trig, in, 1, level trigger that releases ARM.
REQ-011 SHALL have port din, in, DATA_W, sample from the DUT datapath.
REQ-012 SHALL have port din_valid, in, 1, sample qualifier.
REQ-013 SHALL have ports m_axis_tdata (out, DATA_W), m_axis_tkeep (out, DATA_W/8), m_axis_tvalid (out, 1), m_axis_tlast (out, 1) and m_axis_tready (in, 1), forming the stream toward the S2MM sink.
REQ-014 SHALL have ports busy (out, 1), done (out, 1, pulse), aborted (out, 1, sticky), frames_done (out, LEN_W) and drop_cnt (out, LEN_W).

Function
REQ-015 SHALL implement the states IDLE, ARM, RUN, FLUSH and DONE.
REQ-016 SHALL latch cfg_frame_len and cfg_frame_num on cfg_start in IDLE, then enter ARM; cfg_start outside IDLE SHALL be ignored.
REQ-017 In ARM, trig=1 SHALL move to RUN on the next edge; no sample SHALL be taken in ARM.
REQ-018 In RUN, din_valid with the output register empty or draining (!tvalid || tready) SHALL load din into tdata and set tvalid=1 on the next edge, giving 1-cycle latency.
REQ-019 In RUN, din_valid with tvalid=1 and tready=0 SHALL discard the sample and increment drop_cnt, saturating at all-ones.
REQ-020 tlast SHALL be set with the beat whose in-frame index equals frame_len-1, after which the beat index SHALL wrap to 0.
REQ-021 Once tvalid=1, tdata and tlast SHALL hold until tvalid&tready.
REQ-022 tkeep SHALL be all-ones whenever tvalid=1.
REQ-023 Acceptance of a beat with tlast SHALL increment frames_done.
REQ-024 When frames_done reaches a nonzero frame_num, the controller SHALL go RUN->DONE.
REQ-025 DONE SHALL last 1 cycle, assert done=1 and return to IDLE.
REQ-026 cfg_abort in ARM SHALL go to IDLE and set aborted.
REQ-027 cfg_abort in RUN SHALL stop sampling that cycle and go to FLUSH, and SHALL set aborted.
REQ-028 FLUSH SHALL wait for a pending beat to be accepted (unchanged, tlast not forced) and then go to IDLE without a done pulse.
REQ-029 When cfg_abort and a final tlast acceptance occur in the same cycle, completion SHALL win: DONE, aborted unchanged.
REQ-030 busy SHALL be 1 in ARM, RUN and FLUSH.
REQ-031 cfg_start SHALL clear aborted, frames_done and drop_cnt.

Reset
REQ-032 On rst, the block SHALL enter IDLE and drive tvalid=0, tlast=0, tdata=0, busy=0, done=0, aborted=0, frames_done=0 and drop_cnt=0, with the beat index at 0.
REQ-033 rst mid-frame SHALL drop the pending beat without completing the handshake.

Configuration
REQ-034 With S2MM_DROP_CNT_EN defined, drop_cnt SHALL count per REQ-019.
REQ-035 Without S2MM_DROP_CNT_EN, drop_cnt SHALL be the constant 0, no counter logic SHALL exist, and drops SHALL still occur silently.

Structure
REQ-036 The state encoding enum and the tkeep all-ones constant SHALL live in the shared package s2mm_pkg.
REQ-037 The single sub-module s2mm_out_reg SHALL hold the output register, the tvalid/tready handshake and the drop decision; the FSM and counters SHALL stay in the top.

Verification
REQ-038 The bench SHALL check: frame_len=4, frame_num=2, trig=1, din_valid=1 and tready=1 -> 8 beats with tlast on beats 3 and 7, done one cycle after the 8th acceptance, and frames_done=2.
REQ-039 The bench SHALL check: frame_len=0 -> every beat carries tlast=1.
REQ-040 The bench SHALL check: tready=0 for 5 cycles with din_valid=1 in RUN -> drop_cnt=5 and tdata held constant, and with the macro undefined, drop_cnt=0.
REQ-041 The bench SHALL check: frame_num=0 with 3 frames followed by cfg_abort while tvalid=1 and tready=0 -> FLUSH until tready, then IDLE with aborted=1, no done, and frames_done=3.
REQ-042 The bench SHALL check: cfg_start while in RUN -> ignored, with latched config and counters unchanged.
REQ-043 The bench SHALL check: rst asserted at beat 2 of a frame -> the next cycle shows tvalid=0 and IDLE, and a new capture starts its beat index at 0.
